// File: rtl/pn_seq_pkg.sv
// Shared definitions for the PN pattern sequencer: FSM states, pattern codes,
// divider width and small helpers used by the controller and its divider.
package pn_seq_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_PN15  = 2'd0,
    PAT_PN31  = 2'd1,
    PAT_PN511 = 2'd2,
    PAT_ONES  = 2'd3
  } pat_t;

  // Pick the data bit for the selected pattern; all-ones ignores the generator.
  function automatic logic select_bit(input pat_t sel, input logic pn15,
                                      input logic pn31, input logic pn511);
    logic b;
    case (sel)
      PAT_PN15:  b = pn15;
      PAT_PN31:  b = pn31;
      PAT_PN511: b = pn511;
      default:   b = 1'b1;
    endcase
    return b;
  endfunction

  // Low-order mask covering divider bits [div_sel:0].
  function automatic logic [DIV_W-1:0] tick_mask(input logic [2:0] div_sel);
    logic [DIV_W-1:0] m;
    m = '0;
    for (int i = 0; i < DIV_W; i++) begin
      m[i] = (i <= int'(div_sel));
    end
    return m;
  endfunction

endpackage

// File: rtl/pn_seq_div.sv
// Bit-period divider: free-running 8-bit count while running, a one-cycle
// tick when the selected low bits are all ones, and the line clock phase.
module pn_seq_div
  import pn_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       run,
  input  logic [2:0] div_sel,
  output logic       tick,
  output logic       bit_clk
);

  logic [DIV_W-1:0] cnt_div;
  logic [DIV_W-1:0] mask;
  logic             clk_phase;

  assign mask = tick_mask(div_sel);

  // Divider count: cleared while arming, advances every cycle of a run and wraps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_div <= '0;
    end else if (clear) begin
      cnt_div <= '0;
    end else if (run) begin
      cnt_div <= cnt_div + 1'b1;
    end
  end

  // Line clock phase: a registered copy of the selected divider bit, zeroed when arming.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_phase <= 1'b0;
    end else if (clear) begin
      clk_phase <= 1'b0;
    end else begin
      clk_phase <= cnt_div[div_sel];
    end
  end

  assign tick    = run && ((cnt_div & mask) == mask);
  assign bit_clk = run && clk_phase;

endmodule

// File: rtl/pn_seq_ctrl.sv
// PN sequence controller: arms on start, latches the run configuration,
// paces bits from the divider tick, tracks frames and stops on a frame boundary.
module pn_seq_ctrl
  import pn_seq_pkg::*;
#(
  parameter int FRAME_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         pat_sel,
  input  logic [2:0]         div_sel,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               pn15,
  input  logic               pn31,
  input  logic               pn511,
  output logic               pn_adv,
  output logic               bit_clk,
  output logic               bit_data,
  output logic               bit_xd,
  output logic               bit_valid,
  output logic               busy,
  output logic               frame_start,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_cnt
);

  state_t             state;
  state_t             state_next;
  pat_t               pat_q;
  logic [2:0]         div_q;
  logic [FRAME_W-1:0] len_q;
  logic [FRAME_W-1:0] bit_idx;
  logic               stop_pend;
  logic               tick;
  logic               arm;
  logic               run;
  logic               framed;
  logic               last_bit;
  logic               sel_bit;

  assign arm      = (state == ST_ARM);
  assign run      = (state == ST_RUN);
  assign framed   = (len_q != '0);
  assign last_bit = framed && (bit_idx == len_q - 1'b1);
  assign sel_bit  = select_bit(pat_q, pn15, pn31, pn511);
  assign pn_adv   = tick;

  pn_seq_div u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (arm),
    .run     (run),
    .div_sel (div_q),
    .tick    (tick),
    .bit_clk (bit_clk)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and busy: a pending stop ends the run on the last bit of a frame,
  // or on the next bit when running continuously.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_ARM;
      end
      ST_ARM: begin
        busy       = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (stop_pend && (framed ? frame_done : bit_valid)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Run configuration is captured once while arming and held for the whole run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_q <= PAT_PN15;
      div_q <= '0;
      len_q <= '0;
    end else if (arm) begin
      pat_q <= pat_t'(pat_sel);
      div_q <= div_sel;
      len_q <= frame_len;
    end
  end

  // Stop requests only count while running and are dropped outside a run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stop_pend <= 1'b0;
    end else if (!run) begin
      stop_pend <= 1'b0;
    end else if (stop) begin
      stop_pend <= 1'b1;
    end
  end

  // Data path: each tick registers the pattern bit and its running XOR; strobes follow the tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_data    <= 1'b0;
      bit_xd      <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      bit_valid   <= tick;
      frame_start <= tick && framed && (bit_idx == '0);
      frame_done  <= tick && last_bit;
      if (arm) begin
        bit_data <= 1'b0;
        bit_xd   <= 1'b0;
      end else if (tick) begin
        bit_data <= sel_bit;
        bit_xd   <= bit_xd ^ sel_bit;
      end
    end
  end

  // Bit position within the frame, wrapping after the last bit.
  always_ff @(posedge clk) begin
    if (!reset_n || arm) begin
      bit_idx <= '0;
    end else if (tick && framed) begin
      bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
    end
  end

  // Completed-frame counter, saturating so long runs never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!reset_n || arm) begin
      frame_cnt <= '0;
    end else if (tick && last_bit && (frame_cnt != '1)) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pn_seq_ctrl.sv
// Self-checking bench for pn_seq_ctrl: directed and randomized runs compared
// cycle by cycle against an arithmetic model of bit timing, frames and stop.
module tb_pn_seq_ctrl;

  localparam int FRAME_W = 10;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               stop;
  logic [1:0]         pat_sel;
  logic [2:0]         div_sel;
  logic [FRAME_W-1:0] frame_len;
  logic               pn15;
  logic               pn31;
  logic               pn511;
  logic               pn_adv;
  logic               bit_clk;
  logic               bit_data;
  logic               bit_xd;
  logic               bit_valid;
  logic               busy;
  logic               frame_start;
  logic               frame_done;
  logic [CNT_W-1:0]   frame_cnt;

  int checks = 0;
  int errors = 0;
  int run_id = 0;
  int adv_cnt = 0;
  int model_adv = 0;
  bit exp_data = 1'b0;
  bit exp_xd = 1'b0;
  int exp_cnt = 0;

  bit seq15[15];
  bit seq31[31];
  bit seq511[511];

  always #5 clk = ~clk;

  // Behavioural PN source: steps all three sequences whenever the DUT asks.
  always @(posedge clk) begin
    if (pn_adv === 1'b1) adv_cnt <= adv_cnt + 1;
  end

  assign pn15  = seq15[adv_cnt % 15];
  assign pn31  = seq31[adv_cnt % 31];
  assign pn511 = seq511[adv_cnt % 511];

  pn_seq_ctrl #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .pat_sel     (pat_sel),
    .div_sel     (div_sel),
    .frame_len   (frame_len),
    .pn15        (pn15),
    .pn31        (pn31),
    .pn511       (pn511),
    .pn_adv      (pn_adv),
    .bit_clk     (bit_clk),
    .bit_data    (bit_data),
    .bit_xd      (bit_xd),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pat_bit(input int pat, input int g);
    case (pat)
      0:       return seq15[g % 15];
      1:       return seq31[g % 31];
      2:       return seq511[g % 511];
      default: return 1'b1;
    endcase
  endfunction

  // Flags packed as {pn_adv, bit_clk, bit_data, bit_xd, bit_valid, busy, frame_start, frame_done}.
  task automatic checkCycle(input string tag, input bit e_adv, input bit e_clk, input bit e_valid,
                            input bit e_busy, input bit e_fs, input bit e_fd);
    checkOutput({tag, " flags"},
                {24'd0, pn_adv, bit_clk, bit_data, bit_xd, bit_valid, busy, frame_start, frame_done},
                {24'd0, e_adv, e_clk, exp_data, exp_xd, e_valid, e_busy, e_fs, e_fd});
    checkOutput({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
  endtask

  // One run: start from IDLE at a negedge, stop requested in RUN cycle ks,
  // optional reset in RUN cycle rst_k (-1 for none). Cycle k=0 is the first RUN cycle.
  task automatic applyStimulus(input int d, input int pat, input int len, input int ks, input int rst_k);
    int    p;
    int    n;
    int    run_base;
    bit    pend;
    bit    b;
    bit    e_adv;
    bit    e_clk;
    bit    e_valid;
    bit    e_fs;
    bit    e_fd;
    string tag;
    p        = 1 << (d + 1);
    pend     = 1'b0;
    run_base = model_adv;
    run_id++;
    start     = 1'b1;
    stop      = 1'($urandom_range(0, 1));
    pat_sel   = 2'(pat);
    div_sel   = 3'(d);
    frame_len = FRAME_W'(len);
    @(negedge clk);
    checkCycle($sformatf("run%0d arm", run_id), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_data = 1'b0;
    exp_xd   = 1'b0;
    exp_cnt  = 0;
    start    = 1'b0;
    stop     = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      tag     = $sformatf("run%0d k%0d", run_id, k);
      e_adv   = ((k + 1) % p) == 0;
      e_valid = (k >= p) && ((k % p) == 0);
      e_clk   = (k == 0) ? 1'b0 : 1'(((k - 1) >> d) & 1);
      e_fs    = 1'b0;
      e_fd    = 1'b0;
      if (e_valid) begin
        n        = k / p - 1;
        b        = pat_bit(pat, run_base + n);
        exp_data = b;
        exp_xd   = exp_xd ^ b;
        if (len != 0) begin
          e_fs = (n % len) == 0;
          e_fd = (n % len) == len - 1;
          if (e_fd && exp_cnt < CNT_MAX) exp_cnt++;
        end
      end
      if (e_adv) model_adv++;
      checkCycle(tag, e_adv, e_clk, e_valid, 1'b1, e_fs, e_fd);
      if (k == rst_k) begin
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        @(negedge clk);
        exp_data = 1'b0;
        exp_xd   = 1'b0;
        exp_cnt  = 0;
        checkCycle($sformatf("run%0d reset", run_id), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          checkCycle($sformatf("run%0d after reset %0d", run_id, j), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      if (e_valid && pend && (len == 0 || e_fd)) begin
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        checkCycle($sformatf("run%0d idle", run_id), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (k == ks) pend = 1'b1;
      start     = ($urandom_range(0, 3) == 0);
      pat_sel   = 2'($urandom);
      div_sel   = 3'($urandom);
      frame_len = FRAME_W'($urandom);
      stop      = (k == ks);
      if (k == ks) start = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [3:0] s4;
    logic [4:0] s5;
    logic [8:0] s9;
    int d;
    int len;
    s4 = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      seq15[i] = s4[3];
      s4 = {s4[2:0], s4[3] ^ s4[2]};
    end
    s5 = 5'b00001;
    for (int i = 0; i < 31; i++) begin
      seq31[i] = s5[4];
      s5 = {s5[3:0], s5[4] ^ s5[2]};
    end
    s9 = 9'b000000001;
    for (int i = 0; i < 511; i++) begin
      seq511[i] = s9[8];
      s9 = {s9[7:0], s9[8] ^ s9[4]};
    end

    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    pat_sel   = 2'd0;
    div_sel   = 3'd0;
    frame_len = '0;
    repeat (3) @(negedge clk);
    checkCycle("in reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    checkCycle("idle after reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // all-ones, two-cycle bits, 4-bit frames, stop mid-frame
    applyStimulus(0, 3, 4, 5, -1);
    // div_sel=2 timing and line clock, continuous PN15
    applyStimulus(2, 0, 0, 40, -1);
    // 5-bit frames, stop at bit 2
    applyStimulus(1, 1, 5, 12, -1);
    // continuous, stop mid-bit
    applyStimulus(1, 2, 0, 5, -1);
    // long PN15 run with stray start and config changes
    applyStimulus(0, 0, 0, 60, -1);
    // slowest divider
    applyStimulus(7, 1, 0, 0, -1);
    // single-bit frames saturate the counter
    applyStimulus(0, 2, 1, 30, -1);
    // reset mid-frame
    applyStimulus(1, 0, 5, 100000, 30);

    for (int r = 0; r < 12; r++) begin
      d   = $urandom_range(0, 3);
      len = $urandom_range(0, 6);
      applyStimulus(d, $urandom_range(0, 3), len, $urandom_range(0, (1 << (d + 1)) * 8), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pn_seq_ctrl.md
PN_SEQ_CTRL -- requirements
Module: pn_seq_ctrl

Interface
REQ-001 SHALL have parameter FRAME_W, default 10, width of frame_len.
REQ-002 SHALL have parameter CNT_W, default 16, width of frame_cnt.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a pattern run.
REQ-006 SHALL have port stop, input, 1, one-cycle request to end the run at the next frame boundary.
REQ-007 SHALL have port pat_sel, input, 2, pattern select: 0 PN15, 1 PN31, 2 PN511, 3 all-ones.
REQ-008 SHALL have port div_sel, input, 3, bit-period select.
REQ-009 SHALL have port frame_len, input, FRAME_W, bits per frame; 0 means continuous.
REQ-010 SHALL have ports pn15, pn31 and pn511, each an input of width 1, the current bits from the PN generator.
REQ-011 SHALL have port pn_adv, output, 1, advance strobe driving the PN generator's valid input.
REQ-012 SHALL have ports bit_clk, bit_data and bit_xd, each an output of width 1: the line clock, the data bit and the relative-code (differential) bit.
REQ-013 SHALL have port bit_valid, output, 1, one-cycle strobe marking an updated data bit.
REQ-014 SHALL have ports busy, frame_start and frame_done, each an output of width 1: run active, first bit of a frame, last bit of a frame.
REQ-015 SHALL have port frame_cnt, output, CNT_W, count of completed frames.

Function
REQ-016 SHALL implement the states IDLE, ARM and RUN.
REQ-017 SHALL go from IDLE to ARM on start.
REQ-018 SHALL, in ARM, latch pat_sel, div_sel and frame_len, clear the 8-bit divider cnt_div, clear the bit counter and clear frame_cnt, then go to RUN after exactly one cycle.
REQ-019 SHALL ignore start in ARM and RUN, and SHALL NOT alter the latched configuration.
REQ-020 SHALL, in RUN, increment cnt_div every cycle, wrapping modulo 256.
REQ-021 SHALL generate an internal tick for one cycle when cnt_div[div_sel:0] is all ones, so the bit period is 2^(div_sel+1) clk cycles (2 to 256).
REQ-022 SHALL assert pn_adv equal to tick, combinationally.
REQ-023 SHALL, on tick, register bit_data to the selected pattern bit and bit_xd to bit_xd XOR that bit.
REQ-024 SHALL assert bit_valid one cycle after each tick.
REQ-025 SHALL make bit_clk the registered cnt_div[div_sel] while in RUN and 0 otherwise.
REQ-026 SHALL make the first tick occur 2^(div_sel+1) cycles after RUN is entered.
REQ-027 SHALL, when frame_len is nonzero, count ticks from 0 to frame_len-1 and then wrap.
REQ-028 SHALL assert frame_start with the bit_valid of bit 0 and frame_done with the bit_valid of bit frame_len-1.
REQ-029 SHALL increment frame_cnt on frame_done, saturating at all ones.
REQ-030 SHALL, when frame_len is 0, keep frame_start, frame_done and frame_cnt at 0.
REQ-031 SHALL latch stop into stop_pend while in RUN, and SHALL ignore stop in IDLE and ARM.
REQ-032 SHALL honour stop in RUN even when start arrives in the same cycle.
REQ-033 SHALL, with stop_pend set, go from RUN to IDLE on the cycle after the frame_done bit when frame_len is nonzero, or after the next bit_valid when frame_len is 0.
REQ-034 SHALL hold bit_data and bit_xd in IDLE, and SHALL clear both in ARM.
REQ-035 SHALL assert busy in ARM and RUN.

Reset
REQ-036 SHALL, on reset_n low at a clock edge, enter IDLE.
REQ-037 SHALL, on reset, set cnt_div, the bit counter, stop_pend and frame_cnt to 0.
REQ-038 SHALL, on reset, set pn_adv, bit_clk, bit_data, bit_xd, bit_valid, busy, frame_start and frame_done to 0.
REQ-039 SHALL abort any run immediately when reset occurs mid-run, with no frame_done.

Structure
REQ-040 SHALL place the state encoding, the pattern-select codes and the DIV_W=8 constant in the shared package pn_seq_pkg.
REQ-041 SHALL implement the divider and tick as one sub-module, pn_seq_div.

Verification
REQ-042 SHALL test: div_sel=0, frame_len=4, pat_sel=3 -> tick every 2 cycles, bit_data=1, bit_xd toggles 1,0,1,0, frame_done on bit 4, frame_cnt=1.
REQ-043 SHALL test: div_sel=2, start -> first pn_adv 8 cycles after RUN, bit_clk period 8 cycles at 50% duty.
REQ-044 SHALL test: frame_len=5, stop at bit 2 -> bits 3 and 4 still emitted, frame_done once, IDLE next cycle, busy=0.
REQ-045 SHALL test: frame_len=0, stop -> exactly one further bit_valid, then IDLE, with frame_cnt=0.
REQ-046 SHALL test: start while RUN, with pat_sel changed -> no effect, and the PN15 sequence continues.
REQ-047 SHALL test: reset_n low mid-frame -> all outputs 0 next cycle, and no frame_done.
